// File: rtl/mem_mdr_ctrl.sv
// MAR/MDR register pair with a fixed-wait-state SRAM read/write sequencer.
// Optional MEM_ACCESS_CNT_EN adds saturating rd_count/wr_count outputs.
module mem_mdr_ctrl #(
    parameter int WAIT_CYCLES = 2,
    parameter int ADDR_W      = 16
) (
    input  logic              Clk,
    input  logic              Reset_n,
    input  logic [15:0]       bus_in,
    input  logic              LD_MAR,
    input  logic              LD_MDR,
    input  logic              MIO_EN,
    input  logic              mem_rd_req,
    input  logic              mem_wr_req,
    input  logic [15:0]       mem_data_in,
    output logic [15:0]       mar_out,
    output logic [15:0]       mdr_out,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [15:0]       mem_data_out,
    output logic              mem_data_oe,
    output logic              mem_ce_n,
    output logic              mem_oe_n,
    output logic              mem_we_n,
    output logic              busy,
    output logic              done
`ifdef MEM_ACCESS_CNT_EN
    ,
    output logic [15:0]       rd_count,
    output logic [15:0]       wr_count
`endif
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RD,
        S_WR,
        S_DONE
    } state_t;

    localparam logic [3:0] CNT_LOAD = 4'(WAIT_CYCLES - 1);

    state_t      state_q;
    state_t      state_d;
    logic [3:0]  cnt_q;
    logic [15:0] mar_q;
    logic [15:0] mdr_q;
    logic        can_load;
    logic        start;
    logic        last;

    assign can_load = (state_q == S_IDLE) || (state_q == S_DONE);
    assign start    = (state_q == S_IDLE) && (mem_rd_req || mem_wr_req);
    assign last     = (cnt_q == 4'd0);

    // State register
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; a read wins over a simultaneous write
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (mem_rd_req) begin
                    state_d = S_RD;
                end else if (mem_wr_req) begin
                    state_d = S_WR;
                end
            end
            S_RD:   if (last) state_d = S_DONE;
            S_WR:   if (last) state_d = S_DONE;
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Decoded strobes and status for each state
    always_comb begin
        mem_ce_n    = 1'b1;
        mem_oe_n    = 1'b1;
        mem_we_n    = 1'b1;
        mem_data_oe = 1'b0;
        busy        = 1'b0;
        done        = 1'b0;
        unique case (state_q)
            S_RD: begin
                mem_ce_n = 1'b0;
                mem_oe_n = 1'b0;
                busy     = 1'b1;
            end
            S_WR: begin
                mem_ce_n    = 1'b0;
                mem_we_n    = 1'b0;
                mem_data_oe = 1'b1;
                busy        = 1'b1;
            end
            S_DONE: done = 1'b1;
            default: ;
        endcase
    end

    // Wait-state counter: loaded on accept, counts down during the access
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            cnt_q <= 4'd0;
        end else if (start) begin
            cnt_q <= CNT_LOAD;
        end else if (busy && !last) begin
            cnt_q <= cnt_q - 4'd1;
        end
    end

    // MAR loads only when no access is in flight
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            mar_q <= 16'h0000;
        end else if (LD_MAR && can_load) begin
            mar_q <= bus_in;
        end
    end

    // MDR: read-data latch on the final RD edge beats a bus load
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            mdr_q <= 16'h0000;
        end else if ((state_q == S_RD) && last) begin
            mdr_q <= mem_data_in;
        end else if (LD_MDR && !MIO_EN && can_load) begin
            mdr_q <= bus_in;
        end
    end

`ifdef MEM_ACCESS_CNT_EN
    // Completed-access counters, saturating at all-ones
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            rd_count <= 16'h0000;
            wr_count <= 16'h0000;
        end else begin
            if ((state_q == S_RD) && last && (rd_count != 16'hFFFF)) begin
                rd_count <= rd_count + 16'd1;
            end
            if ((state_q == S_WR) && last && (wr_count != 16'hFFFF)) begin
                wr_count <= wr_count + 16'd1;
            end
        end
    end
`endif

    assign mar_out      = mar_q;
    assign mdr_out      = mdr_q;
    assign mem_data_out = mdr_q;
    assign mem_addr     = mar_q[ADDR_W-1:0];

endmodule
